sm_run_ctrl: RTL and testbench
==============================

SM_RUN_CTRL -- requirements
Module: sm_run_ctrl

Interface
REQ-001 SHALL have parameter SHIFT, default 16, meaning the base prescaler bit index, so a tick occurs every 2^(SHIFT+devide+1) clk cycles.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the prescaler width; the value shall satisfy CNT_W >= SHIFT+16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port devide, input, 4 bits: rate select, already synchronized to clk.
REQ-006 SHALL have ports cmdValid (input, 1 bit) and cmdReady (output, 1 bit): the command handshake.
REQ-007 SHALL have port cmd, input, 2 bits: 00 HALT, 01 RUN, 10 STEP, 11 RUN_N.
REQ-008 SHALL have port cmdCount, input, 16 bits: instruction count for RUN_N.
REQ-009 SHALL have ports bpEnable (input, 1 bit) and bpAddr (input, 32 bits): the breakpoint control.
REQ-010 SHALL have port pc, input, 32 bits: the current CPU instruction address (imAddr).
REQ-011 SHALL have port cpuEn, output, 1 bit: a one-cycle CPU clock-enable pulse.
REQ-012 SHALL have port state, output, 2 bits: 0 IDLE, 1 RUN, 2 COUNT, 3 BREAK.
REQ-013 SHALL have port remain, output, 16 bits: the remaining COUNT instructions.
REQ-014 SHALL have port instrCnt, output, 32 bits: the total number of cpuEn pulses issued.

Function
REQ-015 SHALL use a free-running CNT_W-bit prescaler cnt that increments every clk and wraps modulo 2^CNT_W.
REQ-016 SHALL define tick as a one-cycle pulse on the 0->1 transition of cnt[SHIFT+devide], detected against a registered copy of that bit.
REQ-017 SHALL accept that a devide change may produce one spurious or one missed tick; no correction is required.
REQ-018 SHALL drive cmdReady = 1 when state is IDLE or BREAK.
REQ-019 SHALL drive cmdReady = 1 in RUN and COUNT only when cmd == HALT; cmdReady is combinational from state and cmd.
REQ-020 SHALL treat a command as accepted only in a cycle where cmdValid & cmdReady.
REQ-021 SHALL on accepted HALT go to IDLE and leave remain unchanged.
REQ-022 SHALL on accepted RUN go to RUN.
REQ-023 SHALL on accepted STEP go to COUNT with remain = 1.
REQ-024 SHALL on accepted RUN_N with cmdCount != 0 go to COUNT with remain = cmdCount.
REQ-025 SHALL on accepted RUN_N with cmdCount == 0 remain in IDLE and leave remain unchanged, as an accepted no-op.
REQ-026 SHALL set the internal flag bpSkip on any accepted RUN, STEP or RUN_N (including cmdCount == 0), and clear it on the first subsequent cpuEn or on an accepted HALT.
REQ-027 SHALL define bpHit = bpEnable & (pc == bpAddr) & ~bpSkip.
REQ-028 SHALL in RUN or COUNT on tick with bpHit: emit no cpuEn, go to BREAK, and leave remain unchanged.
REQ-029 SHALL in RUN on tick without bpHit: assert cpuEn for exactly that cycle.
REQ-030 SHALL in COUNT on tick without bpHit: assert cpuEn and decrement remain.
REQ-031 SHALL go from COUNT to IDLE when remain decrements to 0, in the same cycle.
REQ-032 SHALL register cpuEn and assert it in the clk cycle immediately after the tick, a fixed latency of 1.
REQ-033 SHALL give an accepted HALT priority over a same-cycle tick, so no cpuEn results from that tick.
REQ-034 SHALL not assert cpuEn from a tick in the same cycle a RUN, STEP or RUN_N is accepted; the first possible pulse follows the next tick.
REQ-035 SHALL never assert cpuEn in IDLE or BREAK.
REQ-036 SHALL increment instrCnt on every cpuEn and wrap from 0xFFFFFFFF to 0.
REQ-037 SHALL ignore cmdValid when cmdReady is 0, with no state change.

Reset
REQ-038 SHALL asynchronously set, on rst high: state = IDLE, cpuEn = 0, remain = 0, instrCnt = 0, cnt = 0, registered tick bit = 0, bpSkip = 0.
REQ-039 SHALL, on rst asserted mid-RUN or mid-COUNT, abort the operation immediately with no further cpuEn.
REQ-040 SHALL restart with the first tick cnt edge counted from 0 after rst deasserts.

Verification
REQ-041 SHALL cover: SHIFT=0, devide=0, accepted RUN -> cpuEn pulses every 2 clk, instrCnt reaches 10 after 10 pulses.
REQ-042 SHALL cover: RUN_N with cmdCount=3 -> exactly 3 cpuEn, remain 3->2->1->0, then state=IDLE.
REQ-043 SHALL cover: RUN_N with cmdCount=0 -> cmdReady=1, state stays IDLE, no cpuEn.
REQ-044 SHALL cover: bpEnable=1, bpAddr=0x10, RUN, pc reaches 0x10 -> no cpuEn on that tick, state=BREAK; a subsequent STEP at pc=0x10 -> exactly 1 cpuEn (bpSkip).
REQ-045 SHALL cover: RUN with cmd=RUN held valid -> cmdReady=0 and state unchanged; HALT asserted coincident with a tick -> no cpuEn, state=IDLE.
REQ-046 SHALL cover: rst pulsed during COUNT with remain=5 -> state=IDLE, remain=0, instrCnt=0, no cpuEn afterwards.

Source files
------------

// File: rtl/sm_run_ctrl_if.sv
// Command channel between the host debugger and the run controller.
// The host side (master) drives the command fields; the controller (slave) answers with cmdReady.
interface sm_run_ctrl_if;
   logic        cmdValid;
   logic        cmdReady;
   logic [1:0]  cmd;
   logic [15:0] cmdCount;

   modport master (output cmdValid, output cmd, output cmdCount, input cmdReady);
   modport slave  (input cmdValid, input cmd, input cmdCount, output cmdReady);
endinterface

// File: rtl/sm_run_ctrl.sv
// Single-step / run controller: paces a CPU clock-enable from a prescaled tick and
// stops on HALT, instruction-count exhaustion or an address breakpoint.
module sm_run_ctrl #(
   parameter int SHIFT = 16,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         devide,
   sm_run_ctrl_if.slave       cmdBus,
   input  logic               bpEnable,
   input  logic [31:0]        bpAddr,
   input  logic [31:0]        pc,
   output logic               cpuEn,
   output logic [1:0]         state,
   output logic [15:0]        remain,
   output logic [31:0]        instrCnt
);

   localparam int IDX_W = $clog2(CNT_W);

   localparam logic [1:0] CMD_HALT  = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_RUN_N = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_COUNT = 2'd2,
      ST_BREAK = 2'd3
   } runState_t;

   runState_t        curState;
   logic [CNT_W-1:0] cnt;
   logic             tickPrev;
   logic             bpSkip;
   logic [IDX_W-1:0] bitIdx;
   logic             tickBit;
   logic             tick;
   logic             accept;
   logic             bpHit;
   logic             active;

   assign bitIdx  = IDX_W'(SHIFT) + IDX_W'(devide);
   assign tickBit = cnt[bitIdx];
   assign tick    = tickBit & ~tickPrev;

   // While the CPU is running only HALT may interrupt; idle or stopped, anything is taken.
   assign active          = (curState == ST_RUN) || (curState == ST_COUNT);
   assign cmdBus.cmdReady = ~active || (cmdBus.cmd == CMD_HALT);
   assign accept          = cmdBus.cmdValid & cmdBus.cmdReady;

   assign bpHit = bpEnable & (pc == bpAddr) & ~bpSkip;
   assign state = curState;

   // Commands take priority over ticks, so a command-accept cycle never issues a pulse.
   // bpSkip lets a resumed run step off the instruction it stopped on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curState <= ST_IDLE;
         cpuEn    <= 1'b0;
         remain   <= 16'd0;
         instrCnt <= 32'd0;
         cnt      <= '0;
         tickPrev <= 1'b0;
         bpSkip   <= 1'b0;
      end else begin
         cnt      <= cnt + CNT_W'(1);
         tickPrev <= tickBit;
         cpuEn    <= 1'b0;
         if (accept) begin
            case (cmdBus.cmd)
               CMD_HALT: begin
                  curState <= ST_IDLE;
                  bpSkip   <= 1'b0;
               end
               CMD_RUN: begin
                  curState <= ST_RUN;
                  bpSkip   <= 1'b1;
               end
               CMD_STEP: begin
                  curState <= ST_COUNT;
                  remain   <= 16'd1;
                  bpSkip   <= 1'b1;
               end
               CMD_RUN_N: begin
                  if (cmdBus.cmdCount != 16'd0) begin
                     curState <= ST_COUNT;
                     remain   <= cmdBus.cmdCount;
                  end
                  bpSkip <= 1'b1;
               end
               default: curState <= ST_IDLE;
            endcase
         end else if (tick && active) begin
            if (bpHit) begin
               curState <= ST_BREAK;
            end else begin
               cpuEn    <= 1'b1;
               instrCnt <= instrCnt + 32'd1;
               bpSkip   <= 1'b0;
               if (curState == ST_COUNT) begin
                  remain <= remain - 16'd1;
                  if (remain == 16'd1) begin
                     curState <= ST_IDLE;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Directed bench for sm_run_ctrl with SHIFT=0 so ticks arrive every 2 clocks at devide=0.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_sm_run_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  devide;
   logic        bpEnable;
   logic [31:0] bpAddr;
   logic [31:0] pc;
   logic        cpuEn;
   logic [1:0]  state;
   logic [15:0] remain;
   logic [31:0] instrCnt;

   int checks = 0;
   int errors = 0;

   sm_run_ctrl_if cmdBus();

   sm_run_ctrl #(.SHIFT(0), .CNT_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .devide   (devide),
      .cmdBus   (cmdBus.slave),
      .bpEnable (bpEnable),
      .bpAddr   (bpAddr),
      .pc       (pc),
      .cpuEn    (cpuEn),
      .state    (state),
      .remain   (remain),
      .instrCnt (instrCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one command for a single clock; returns on the negedge after acceptance.
   task automatic issueCmd(input logic [1:0] c, input logic [15:0] n);
      @(negedge clk);
      cmdBus.cmdValid = 1'b1;
      cmdBus.cmd      = c;
      cmdBus.cmdCount = n;
      @(negedge clk);
      cmdBus.cmdValid = 1'b0;
   endtask

   task automatic countPulses(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (cpuEn) pulses++;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
      checks++; if (cpuEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpuEn got %b want 0", cpuEn); end
      checks++; if (remain !== 16'd0) begin errors++; $display("[TB] FAIL reset_remain got %0d want 0", remain); end
      checks++; if (instrCnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_instrCnt got %0d want 0", instrCnt); end
      checks++; if (cmdBus.cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmdReady got %b want 1", cmdBus.cmdReady); end
      rst = 1'b0;
   endtask

   task automatic test_run();
      int pulses;
      int doubles;
      logic prevEn;
      issueCmd(2'b01, 16'd0);
      checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL run_state got %0d want 1", state); end
      pulses = 0; doubles = 0; prevEn = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpuEn) pulses++;
         if (cpuEn && prevEn) doubles++;
         prevEn = cpuEn;
      end
      checks++; if (pulses != 10) begin errors++; $display("[TB] FAIL run_pulses got %0d want 10", pulses); end
      checks++; if (doubles != 0) begin errors++; $display("[TB] FAIL run_spacing got %0d back-to-back want 0", doubles); end
      checks++; if (instrCnt !== 32'd10) begin errors++; $display("[TB] FAIL run_instrCnt got %0d want 10", instrCnt); end
      cmdBus.cmd = 2'b00;
      #1;
      checks++; if (cmdBus.cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL run_haltReady got %b want 1", cmdBus.cmdReady); end
      issueCmd(2'b00, 16'd0);
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL run_haltState got %0d want 0", state); end
      countPulses(6, pulses);
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL idle_pulses got %0d want 0", pulses); end
   endtask

   task automatic test_devide();
      int pulses;
      devide = 4'd1;
      repeat (6) @(negedge clk);
      issueCmd(2'b01, 16'd0);
      countPulses(40, pulses);
      checks++; if (pulses != 10) begin errors++; $display("[TB] FAIL devide1_pulses got %0d want 10", pulses); end
      issueCmd(2'b00, 16'd0);
      devide = 4'd0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_run_n();
      int pulses;
      issueCmd(2'b11, 16'd3);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL runn_state got %0d want 2", state); end
      checks++; if (remain !== 16'd3) begin errors++; $display("[TB] FAIL runn_remain got %0d want 3", remain); end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpuEn) begin
            pulses++;
            checks++;
            if (remain !== 16'(3 - pulses)) begin
               errors++; $display("[TB] FAIL runn_remainStep got %0d want %0d", remain, 3 - pulses);
            end
            if (pulses == 3) begin
               checks++;
               if (state !== 2'd0) begin errors++; $display("[TB] FAIL runn_doneState got %0d want 0", state); end
            end
         end
      end
      checks++; if (pulses != 3) begin errors++; $display("[TB] FAIL runn_pulses got %0d want 3", pulses); end
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL runn_endState got %0d want 0", state); end
   endtask

   task automatic test_halt_keeps_remain();
      int pulses;
      logic found;
      issueCmd(2'b11, 16'd5);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (cpuEn) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL runn5_firstPulse got none want 1 within 10 cycles"); end
      checks++; if (remain !== 16'd4) begin errors++; $display("[TB] FAIL runn5_remain got %0d want 4", remain); end
      cmdBus.cmdValid = 1'b1;
      cmdBus.cmd      = 2'b00;
      @(negedge clk);
      cmdBus.cmdValid = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL halt_state got %0d want 0", state); end
      checks++; if (remain !== 16'd4) begin errors++; $display("[TB] FAIL halt_remain got %0d want 4", remain); end
      cmdBus.cmdValid = 1'b1;
      cmdBus.cmd      = 2'b11;
      cmdBus.cmdCount = 16'd0;
      #1;
      checks++; if (cmdBus.cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL runn0_ready got %b want 1", cmdBus.cmdReady); end
      @(negedge clk);
      cmdBus.cmdValid = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL runn0_state got %0d want 0", state); end
      checks++; if (remain !== 16'd4) begin errors++; $display("[TB] FAIL runn0_remain got %0d want 4", remain); end
      countPulses(8, pulses);
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL runn0_pulses got %0d want 0", pulses); end
   endtask

   task automatic test_held_run_and_halt_tick();
      int pulses;
      logic found;
      issueCmd(2'b01, 16'd0);
      cmdBus.cmdValid = 1'b1;
      cmdBus.cmd      = 2'b01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (cmdBus.cmdReady !== 1'b0) begin errors++; $display("[TB] FAIL held_ready got %b want 0", cmdBus.cmdReady); end
         checks++; if (state !== 2'd1) begin errors++; $display("[TB] FAIL held_state got %0d want 1", state); end
      end
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (cpuEn) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL held_pulse got none want 1 within 10 cycles"); end
      @(negedge clk);
      cmdBus.cmd = 2'b00;
      @(negedge clk);
      cmdBus.cmdValid = 1'b0;
      checks++; if (cpuEn !== 1'b0) begin errors++; $display("[TB] FAIL haltTick_cpuEn got %b want 0", cpuEn); end
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL haltTick_state got %0d want 0", state); end
      countPulses(6, pulses);
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL haltTick_after got %0d want 0", pulses); end
   endtask

   task automatic test_breakpoint();
      int pulses;
      logic done;
      pc       = 32'h0;
      bpAddr   = 32'h10;
      bpEnable = 1'b1;
      issueCmd(2'b01, 16'd0);
      pulses = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (cpuEn) begin pulses++; pc = pc + 32'd4; end
         if (state == 2'd3) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("[TB] FAIL bp_break got state %0d want 3 within 40 cycles", state); end
      checks++; if (pulses != 4) begin errors++; $display("[TB] FAIL bp_pulses got %0d want 4", pulses); end
      checks++; if (pc !== 32'h10) begin errors++; $display("[TB] FAIL bp_pc got %h want 10", pc); end
      checks++; if (cmdBus.cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready got %b want 1", cmdBus.cmdReady); end
      countPulses(6, pulses);
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL bp_breakPulses got %0d want 0", pulses); end
      issueCmd(2'b10, 16'd0);
      checks++; if (state !== 2'd2) begin errors++; $display("[TB] FAIL step_state got %0d want 2", state); end
      checks++; if (remain !== 16'd1) begin errors++; $display("[TB] FAIL step_remain got %0d want 1", remain); end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cpuEn) begin pulses++; pc = pc + 32'd4; end
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL step_pulses got %0d want 1", pulses); end
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL step_endState got %0d want 0", state); end
      bpEnable = 1'b0;
   endtask

   task automatic test_reset_mid_count();
      int pulses;
      issueCmd(2'b11, 16'd5);
      checks++; if (remain !== 16'd5) begin errors++; $display("[TB] FAIL rstc_remain got %0d want 5", remain); end
      rst = 1'b1;
      #1;
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rstc_state got %0d want 0", state); end
      checks++; if (remain !== 16'd0) begin errors++; $display("[TB] FAIL rstc_remainClr got %0d want 0", remain); end
      checks++; if (instrCnt !== 32'd0) begin errors++; $display("[TB] FAIL rstc_instrCnt got %0d want 0", instrCnt); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      countPulses(10, pulses);
      checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL rstc_pulses got %0d want 0", pulses); end
      checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL rstc_after got %0d want 0", state); end
   endtask

   initial begin
      rst             = 1'b1;
      devide          = 4'd0;
      bpEnable        = 1'b0;
      bpAddr          = 32'h0;
      pc              = 32'h0;
      cmdBus.cmdValid = 1'b0;
      cmdBus.cmd      = 2'b00;
      cmdBus.cmdCount = 16'd0;
      test_reset();
      test_run();
      test_devide();
      test_run_n();
      test_halt_keeps_remain();
      test_held_run_and_halt_tick();
      test_breakpoint();
      test_reset_mid_count();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
